// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Merges two write requesters (A and B) onto the single write port of a
// register file. Requesters use a valid/ready handshake. When both request
// in the same cycle, a one-bit priority pointer picks the winner and then
// flips, so sustained contention alternates A,B,A,B. The write port outputs
// are registered, which gives one cycle of latency from handshake to
// write strobe. Register 0 is hard-wired to zero, so a transfer to address 0
// is accepted but never produces a write strobe.
//
// Optional feature macro: REGFILE_ARB_STATS_EN
//   When defined, a saturating 16-bit counter (conflict_count) counts the
//   clock edges on which both requesters were valid.
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous active-high reset
//   a_valid        requester A has a write pending
//   a_addr         requester A destination register
//   a_data         requester A write data
//   a_ready        requester A accepted this cycle (combinational)
//   b_valid/b_addr/b_data/b_ready  same for requester B
//   write_en       registered write strobe to the regfile
//   write_addr     registered write address
//   write_data     registered write data
//   conflict_count dual-valid edge count (only with REGFILE_ARB_STATS_EN)

module regfile_write_arbiter #(
  parameter int WORDSIZE = 64,
  parameter int ADDRW    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  input  logic [ADDRW-1:0]    a_addr,
  input  logic [WORDSIZE-1:0] a_data,
  output logic                a_ready,
  input  logic                b_valid,
  input  logic [ADDRW-1:0]    b_addr,
  input  logic [WORDSIZE-1:0] b_data,
  output logic                b_ready,
  output logic                write_en,
  output logic [ADDRW-1:0]    write_addr,
  output logic [WORDSIZE-1:0] write_data
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [15:0]         conflict_count
`endif
);

  // prio_q: 0 = A wins a tie, 1 = B wins a tie.
  logic                prio_q, prio_d;
  logic                write_en_q, write_en_d;
  logic [ADDRW-1:0]    write_addr_q, write_addr_d;
  logic [WORDSIZE-1:0] write_data_q, write_data_d;

  // Grant decision. Ready is held low during reset so that nothing can be
  // accepted in a cycle where the resulting write would be discarded.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!rst) begin
      if (a_valid && (!b_valid || !prio_q)) begin
        a_ready = 1'b1;
      end else if (b_valid) begin
        b_ready = 1'b1;
      end
    end
  end

  // Next-state for the priority pointer and the registered write port.
  // Address and data only update on an issued write so they hold their
  // last values while the strobe is low. A transfer to register 0 still
  // counts as a grant for fairness purposes.
  always_comb begin
    prio_d       = prio_q;
    write_en_d   = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (a_ready) begin
      prio_d = 1'b1;
      if (a_addr != '0) begin
        write_en_d   = 1'b1;
        write_addr_d = a_addr;
        write_data_d = a_data;
      end
    end else if (b_ready) begin
      prio_d = 1'b0;
      if (b_addr != '0) begin
        write_en_d   = 1'b1;
        write_addr_d = b_addr;
        write_data_d = b_data;
      end
    end
  end

  // State registers; reset clears a pending write immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q       <= 1'b0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      prio_q       <= prio_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign write_en   = write_en_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] conflict_count_q, conflict_count_d;

  // Count edges with both requesters valid, saturating at all-ones.
  always_comb begin
    conflict_count_d = conflict_count_q;
    if (a_valid && b_valid && (conflict_count_q != 16'hFFFF)) begin
      conflict_count_d = conflict_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_count_q <= 16'd0;
    end else begin
      conflict_count_q <= conflict_count_d;
    end
  end

  assign conflict_count = conflict_count_q;
`endif

endmodule
